// File: rtl/fft_avalon_sink_responder_pkg.sv
// fft_avs_resp_pkg: shared types and constants for the Avalon sink responder
package fft_avs_resp_pkg;
    typedef enum logic {IDLE, STALL} resp_state_t;
    localparam logic [31:0] RESP_BAD_DATA = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/fft_avalon_sink_responder_if.sv
// fft_avalon_sink_responder_if: Avalon-MM bus between the FFT results master and the sink
interface fft_avalon_sink_responder_if;
    logic [31:0] avs_address;
    logic        avs_write;
    logic        avs_read;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    modport master (output avs_address, avs_write, avs_read, avs_writedata,
                    input avs_readdata, avs_readdatavalid, avs_waitrequest);
    modport slave (input avs_address, avs_write, avs_read, avs_writedata,
                   output avs_readdata, avs_readdatavalid, avs_waitrequest);
endinterface

// File: rtl/fft_avalon_sink_responder_read_pipe.sv
// avs_read_pipe: fixed-latency read return pipe; data stages only load behind a valid so readdata holds
module avs_read_pipe #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);
    logic [LATENCY-1:0] v;
    logic [31:0]        d [LATENCY];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            d[0] <= in_valid ? in_data : d[0];
            for (int i = 1; i < LATENCY; i++) begin
                v[i] <= v[i-1];
                d[i] <= v[i-1] ? d[i-1] : d[i];
            end
        end
    assign out_valid = v[LATENCY-1];
    assign out_data  = d[LATENCY-1];
endmodule

// File: rtl/fft_avalon_sink_responder.sv
// fft_avalon_sink_responder: Avalon-MM sink with programmable stalls, word buffer and write counting.
// Define FFT_RESP_LFSR_STALL_EN to add 0..3 pseudo-random extra stall cycles per transfer.
module fft_avalon_sink_responder
    import fft_avs_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          DEPTH           = 512,
    parameter int          WAIT_CYCLES     = 3,
    parameter int          READ_LATENCY    = 2,
    parameter int          EXPECTED_WRITES = 512,
    localparam int         IDX_W           = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    fft_avalon_sink_responder_if.slave avs,
    input  logic                    clr,
    input  logic [IDX_W-1:0]        peek_index,
    output logic [31:0]             peek_data,
    output logic [15:0]             write_count,
    output logic [7:0]              oor_count,
    output logic                    done
);
    resp_state_t state, state_n;
    logic [15:0] cnt, cnt_n, stall_len;
    logic        cmd, is_wr, accept, in_range, wr_ok, oor_hit, done_hit, done_seen;
    logic [31:0] off;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem [DEPTH];

`ifdef FFT_RESP_LFSR_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= lfsr[0] ? (lfsr >> 1) ^ LFSR_TAPS : lfsr >> 1;
    assign stall_len = 16'(WAIT_CYCLES) + {14'd0, lfsr[1:0]};
`else
    assign stall_len = 16'(WAIT_CYCLES);
`endif

    assign cmd   = avs.avs_write | avs.avs_read;
    assign is_wr = avs.avs_write;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        if (!cmd) state_n = IDLE;
        else if (state == IDLE) begin
            accept  = stall_len == 16'd0;
            state_n = accept ? IDLE : STALL;
            cnt_n   = stall_len - 16'd1;
        end else begin
            accept  = cnt == 16'd0;
            state_n = accept ? IDLE : STALL;
            cnt_n   = cnt - 16'd1;
        end
    end
    assign avs.avs_waitrequest = rst | (cmd & ~accept);

    // Subtraction wraps so addresses below BASE_ADDR decode as out of range
    assign off      = avs.avs_address - BASE_ADDR;
    assign in_range = off < 32'(DEPTH * 4) && off[1:0] == 2'b00;
    assign idx      = off[IDX_W+1:2];
    assign wr_ok    = accept & is_wr & in_range;
    assign oor_hit  = accept & ~in_range;
    assign done_hit = wr_ok & ~done_seen & (write_count + 16'd1 == 16'(EXPECTED_WRITES));

    always_ff @(posedge clk)
        if (wr_ok) mem[idx] <= avs.avs_writedata;
    assign peek_data = mem[peek_index];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            write_count <= '0;
            oor_count   <= '0;
            done        <= 1'b0;
            done_seen   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (clr) begin
                write_count <= '0;
                oor_count   <= '0;
                done        <= 1'b0;
                done_seen   <= 1'b0;
            end else begin
                write_count <= write_count + 16'(wr_ok);
                oor_count   <= oor_count + 8'(oor_hit && oor_count != 8'hFF);
                done        <= done_hit;
                done_seen   <= done_seen | done_hit;
            end
        end

    avs_read_pipe #(.LATENCY(READ_LATENCY)) u_read_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept & ~is_wr),
        .in_data  (in_range ? mem[idx] : RESP_BAD_DATA),
        .out_valid(avs.avs_readdatavalid),
        .out_data (avs.avs_readdata)
    );
endmodule

// File: tb/tb_fft_avalon_sink_responder.sv
// tb_fft_avalon_sink_responder: table vectors, hand sequences and random traffic against a transaction-level model
module tb_fft_avalon_sink_responder;
    import fft_avs_resp_pkg::*;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int DEPTH = 512, WAIT = 3, LAT = 2, EXP = 512;

    logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
    logic [8:0]  peek_index = '0;
    logic [31:0] peek_data;
    logic [15:0] write_count;
    logic [7:0]  oor_count;
    logic        done;

    fft_avalon_sink_responder_if bus();

    fft_avalon_sink_responder #(
        .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT),
        .READ_LATENCY(LAT), .EXPECTED_WRITES(EXP)
    ) dut (
        .clk(clk), .rst(rst), .avs(bus), .clr(clr), .peek_index(peek_index),
        .peek_data(peek_data), .write_count(write_count), .oor_count(oor_count), .done(done)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, fails = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model of the sink
    logic [31:0] mem_m [DEPTH];
    int wc_m = 0, oor_m = 0, done_cyc = -1, done_pulses = 0;
    bit seen_m = 0;
    typedef struct { int cyc; logic [31:0] data; } ret_t;
    ret_t rq[$];
    ret_t mon_r;

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (o < DEPTH * 4) && (o % 4 == 0);
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) / 4) % DEPTH;
    endfunction
    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return in_rng(a) ? mem_m[widx(a)] : 32'hDEAD_BEEF;
    endfunction
    task automatic model_clear();
        wc_m = 0; oor_m = 0; seen_m = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("done", done, cyc == done_cyc);
            if (done) done_pulses++;
            if (bus.avs_readdatavalid) begin
                if (rq.size() == 0) chk("rdv_unexpected", bus.avs_readdatavalid, 0);
                else begin
                    mon_r = rq.pop_front();
                    chk("rdv_cycle", cyc, mon_r.cyc);
                    chk("readdata", bus.avs_readdata, mon_r.data);
                end
            end else if (rq.size() > 0 && cyc >= rq[0].cyc) begin
                chk("rdv_missing", bus.avs_readdatavalid, 1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic xfer(input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        int stalls, acc;
        stalls = 0;
        @(negedge clk);
        bus.avs_address = a; bus.avs_write = w; bus.avs_read = r; bus.avs_writedata = d;
        #1;
        while (bus.avs_waitrequest && stalls < 20) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (bus.avs_waitrequest) begin
            chk("accept_timeout", bus.avs_waitrequest, 0);
            bus.avs_write = 0; bus.avs_read = 0;
            return;
        end
`ifdef FFT_RESP_LFSR_STALL_EN
        chk("stall_range", stalls >= WAIT && stalls <= WAIT + 3, 1);
`else
        chk("stall_len", stalls, WAIT);
`endif
        acc = cyc;
        @(posedge clk);
        if (!w) rq.push_back('{acc + LAT, exp_rd});
        if (!in_rng(a)) oor_m = oor_m < 255 ? oor_m + 1 : 255;
        else if (w) begin
            mem_m[widx(a)] = d;
            wc_m = (wc_m + 1) % 65536;
            if (wc_m == EXP && !seen_m) begin seen_m = 1; done_cyc = acc + 1; end
        end
        @(negedge clk);
        bus.avs_write = 0; bus.avs_read = 0;
        #1;
        chk("write_count", write_count, wc_m);
        chk("oor_count", oor_count, oor_m);
        if (w && in_rng(a)) begin
            peek_index = 9'(widx(a));
            #1 chk("peek", peek_data, mem_m[widx(a)]);
        end
    endtask

    task automatic do_clr();
        @(negedge clk) clr = 1;
        @(negedge clk) clr = 0;
        model_clear();
        #1 chk("clr_wc", write_count, 0);
    endtask

    typedef struct {
        bit w, r;
        logic [31:0] addr, data, exp_rd;
        logic [15:0] exp_wc;
        logic [7:0]  exp_oor;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0, 32'h010, 32'h100,       32'h0,         1, 0};
        tbl[1] = '{0, 1, 32'h010, 32'h0,         32'h100,       1, 0};
        tbl[2] = '{0, 1, 32'h010, 32'h0,         32'h100,       1, 0};
        tbl[3] = '{1, 0, 32'h800, 32'h1234_5678, 32'h0,         1, 1};
        tbl[4] = '{1, 0, 32'h002, 32'h0000_9ABC, 32'h0,         1, 2};
        tbl[5] = '{0, 1, 32'h800, 32'h0,         32'hDEAD_BEEF, 1, 3};
        tbl[6] = '{0, 1, 32'h000, 32'h0,         32'h7,         1, 3};
        tbl[7] = '{1, 1, 32'h014, 32'h0000_CAFE, 32'h0,         2, 3};
        tbl[8] = '{0, 1, 32'h014, 32'h0,         32'h0000_CAFE, 2, 3};
        tbl[9] = '{0, 1, 32'h7FC, 32'h0,         32'h604,       2, 3};

        bus.avs_address = '0; bus.avs_write = 0; bus.avs_read = 0; bus.avs_writedata = '0;
        repeat (3) @(negedge clk);
        bus.avs_write = 1;
        #1;
        chk("rst_waitrequest", bus.avs_waitrequest, 1);
        chk("rst_rdv", bus.avs_readdatavalid, 0);
        chk("rst_wc", write_count, 0);
        chk("rst_oor", oor_count, 0);
        chk("rst_done", done, 0);
        bus.avs_write = 0;
        @(negedge clk) rst = 0;
        #1 chk("idle_waitrequest", bus.avs_waitrequest, 0);

        for (int i = 0; i < DEPTH; i++) xfer(1, 0, BASE + 32'(i * 4), 32'(i * 3 + 7), '0);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_pulses, 1);
        do_clr();

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].w, tbl[i].r, BASE + tbl[i].addr, tbl[i].data, tbl[i].exp_rd);
            chk("tbl_wc", write_count, tbl[i].exp_wc);
            chk("tbl_oor", oor_count, tbl[i].exp_oor);
        end

        // Master abandons a write mid-stall
        @(negedge clk);
        bus.avs_address = BASE + 32'h20; bus.avs_writedata = 32'h55; bus.avs_write = 1;
        repeat (2) @(negedge clk);
        bus.avs_write = 0;
        repeat (2) @(negedge clk);
        peek_index = 9'd8;
        #1 chk("drop_peek", peek_data, mem_m[8]);
        chk("drop_wc", write_count, wc_m);

        // Reset lands in the middle of a stall
        @(negedge clk);
        bus.avs_address = BASE + 32'h24; bus.avs_writedata = 32'h66; bus.avs_write = 1;
        @(negedge clk) rst = 1;
        rq.delete(); model_clear(); done_cyc = -1;
        #1 chk("rst_stall_waitrequest", bus.avs_waitrequest, 1);
        @(negedge clk) rst = 0;
        bus.avs_write = 0;
        peek_index = 9'd9;
        #1 chk("rst_stall_peek", peek_data, mem_m[9]);
        chk("rst_stall_wc", write_count, 0);

        // Reset pulse with a read still in the pipe
        xfer(0, 1, BASE + 32'h30, '0, model_rd(BASE + 32'h30));
        #1 rst = 1;
        rq.delete(); model_clear(); done_cyc = -1;
        #2 rst = 0;
        repeat (4) @(negedge clk);
        xfer(1, 0, BASE + 32'h28, 32'hABCD, '0);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int sel, op;
            sel = $urandom_range(0, 3);
            op  = $urandom_range(0, 2);
            a = sel < 2 ? BASE + 32'($urandom_range(0, DEPTH - 1) * 4)
              : sel == 2 ? BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3))
              : $urandom;
            if ($urandom_range(0, 19) == 0) do_clr();
            xfer(op != 1, op != 0, a, $urandom, model_rd(a));
        end

        repeat (5) @(negedge clk);
        chk("reads_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
